// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge-magnitude stage.
// Two line buffers plus a 3x3 window feed a registered |Gx|+|Gy| result,
// saturated to 12 bits. Results appear two clocks after the pixel that
// completes a window.
// Build option: define SOBEL_THRESH_EN to binarize the output against THRESH.
module sobel_filter #(
    parameter int unsigned IMG_WIDTH = 640,
    parameter logic [11:0] THRESH    = 12'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [11:0] pix_in,
    output logic        edge_valid,
    output logic [11:0] edge_out
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = 16;

    logic [11:0]      line1 [IMG_WIDTH];   // row r-1
    logic [11:0]      line2 [IMG_WIDTH];   // row r-2
    logic [11:0]      win   [3][3];        // [row: 0=oldest][col: 0=left]
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             armed;
    logic             win_valid;

    logic             accept;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             last_col;
    logic [11:0]      lb1_rd;
    logic [11:0]      lb2_rd;

    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic [15:0]        ax;
    logic [15:0]        ay;
    logic [15:0]        mag;
    logic [11:0]        result;

    function automatic logic signed [15:0] ext(input logic [11:0] p);
        return signed'({4'b0000, p});
    endfunction

    // Position of the pixel presented this cycle; frame_start forces (0,0).
    always_comb begin
        accept   = pix_valid && (armed || frame_start);
        cur_col  = frame_start ? '0 : col;
        cur_row  = frame_start ? '0 : row;
        last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
        lb1_rd   = line1[cur_col];
        lb2_rd   = line2[cur_col];
    end

    // Line buffers: cascade r-1 into r-2 at the current column (not reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            line1[cur_col] <= pix_in;
            line2[cur_col] <= line1[cur_col];
        end
    end

    // Position counters, arming and the sliding window.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            armed     <= 1'b0;
            win_valid <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            win_valid <= 1'b0;
            if (accept) begin
                armed <= 1'b1;
                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= pix_in;
                win_valid <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
                if (last_col) begin
                    col <= '0;
                    row <= (cur_row == '1) ? cur_row : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    // Gradient magnitude from the current window.
    always_comb begin
        gx  = (ext(win[0][2]) + ext(win[1][2]) + ext(win[1][2]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[1][0]) + ext(win[1][0]) + ext(win[2][0]));
        gy  = (ext(win[2][0]) + ext(win[2][1]) + ext(win[2][1]) + ext(win[2][2]))
            - (ext(win[0][0]) + ext(win[0][1]) + ext(win[0][1]) + ext(win[0][2]));
        ax  = gx[15] ? (16'd0 - 16'(gx)) : 16'(gx);
        ay  = gy[15] ? (16'd0 - 16'(gy)) : 16'(gy);
        mag = ax + ay;
`ifdef SOBEL_THRESH_EN
        result = (mag >= {4'b0000, THRESH}) ? '1 : '0;
`else
        result = (mag > 16'd4095) ? '1 : mag[11:0];
`endif
    end

`ifndef SOBEL_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    // Output register: one pulse per completed window.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_valid <= 1'b0;
            edge_out   <= '0;
        end else begin
            edge_valid <= win_valid;
            if (win_valid) begin
                edge_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Testbench for sobel_filter (IMG_WIDTH=8). An image-level model computes the
// Sobel result for every window centre and the cycle it must appear on.
module tb_sobel_filter;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int TH = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] pix_in = '0;
    logic        edge_valid;
    logic [11:0] edge_out;

    always #5 clk = ~clk;

    sobel_filter #(.IMG_WIDTH(W), .THRESH(12'(TH))) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pix_in(pix_in),
        .edge_valid(edge_valid),
        .edge_out(edge_out)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   log_q[$];
    int   ref_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   img [0:15][0:W-1];
    int   mr = 0;
    int   mc = 0;
    bit   marmed = 1'b0;
    bit   started = 1'b0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected output for the window centred at image (r, c).
    function automatic int sobel_at(input int r, input int c);
        int gx, gy, m;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        m = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESH_EN
        return (m >= TH) ? 4095 : 0;
`else
        return (m > 4095) ? 4095 : m;
`endif
    endfunction

    // Model: track frame position, store pixels, schedule expected results.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            marmed = 1'b0;
        end else if (pix_valid && (marmed || frame_start)) begin
            if (frame_start) begin
                mr = 0;
                mc = 0;
                marmed = 1'b1;
            end
            img[mr][mc] = int'(pix_in);
            if (mr >= 2 && mc >= 2)
                q.push_back('{sobel_at(mr - 1, mc - 1), cyc + 1});
            if (mc == W - 1) begin
                mc = 0;
                if (mr < 15) mr = mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
    end

    // Compare DUT against model every cycle an output is present or due.
    always @(negedge clk) begin
        bit has;
        if (started) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL stale_expect: result due cycle %0d never seen (now %0d)", q[0].due, cyc);
                void'(q.pop_front());
            end
            has = (q.size() > 0) && (q[0].due == cyc);
            if (edge_valid === 1'b1) log_q.push_back(int'(edge_out));
            if (edge_valid === 1'b1 || has) begin
                checks = checks + 1;
                if (!has) begin
                    errors = errors + 1;
                    $display("FAIL spurious_valid: edge_valid=1 at cycle %0d, required 0", cyc);
                end else if (edge_valid !== 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL missing_valid: edge_valid=%b at cycle %0d, required 1", edge_valid, cyc);
                end else if (int'(edge_out) != q[0].val) begin
                    errors = errors + 1;
                    $display("FAIL edge_out: got %0d at cycle %0d, required %0d", edge_out, cyc, q[0].val);
                end
                if (has) void'(q.pop_front());
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit fs, input int d);
        @(posedge clk);
        #1;
        pix_valid   = v;
        frame_start = fs;
        pix_in      = 12'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0);
    endtask

    function automatic int pixval(input int kind, input int r, input int c);
        case (kind)
            0:       return 700;
            1:       return (c < 4) ? 0 : 100;
            2:       return (c < 4) ? 0 : 4095;
            default: return (r * 331 + c * c * 97 + c * 13) % 4096;
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
                drive(1'b1, (r == 0 && c == 0), pixval(kind, r, c));
            end
        end
        idle(4);
    endtask

    task automatic check_step(input string name, input int hi);
        int pat [6];
        pat = '{0, 0, hi, hi, 0, 0};
        check({name, "_count"}, log_q.size(), 12);
        for (int i = 0; i < log_q.size() && i < 12; i++)
            check(name, log_q[i], pat[i % 6]);
    endtask

    initial begin
        int v400;
`ifdef SOBEL_THRESH_EN
        v400 = 4095;
`else
        v400 = 400;
`endif
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        check("reset_edge_valid", int'(edge_valid), 0);
        check("reset_edge_out", int'(edge_out), 0);
        rst = 1'b0;

        // Pixels before any frame_start are discarded.
        log_q.delete();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, (i * 200) % 4096);
        idle(4);
        check("unarmed_pulses", log_q.size(), 0);

        // Flat image: 12 zero results.
        log_q.delete();
        send_frame(0, 1'b0);
        check("const_count", log_q.size(), 12);
        for (int i = 0; i < log_q.size(); i++) check("const_val", log_q[i], 0);

        // Step 0/100.
        log_q.delete();
        send_frame(1, 1'b0);
        check_step("step100", v400);

        // Aborted partial frame, then step 0/4095 (saturation).
        for (int i = 0; i < 20; i++) drive(1'b1, (i == 0), 333 + i * 50);
        idle(4);
        log_q.delete();
        send_frame(2, 1'b0);
        check_step("step4095", 4095);

        // Same textured image at full rate and with random gaps.
        log_q.delete();
        send_frame(3, 1'b0);
        ref_q = log_q;
        log_q.delete();
        send_frame(3, 1'b1);
        check("gap_count", log_q.size(), ref_q.size());
        for (int i = 0; i < log_q.size() && i < ref_q.size(); i++)
            check("gap_seq", log_q[i], ref_q[i]);

        // Reset while the row-2/col-2 result is in flight.
        log_q.delete();
        for (int i = 0; i < 2 * W + 3; i++) drive(1'b1, (i == 0), pixval(3, i / W, i % W));
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        check("valid_after_rst", int'(edge_valid), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4000);
        idle(4);
        check("rst_dropped", log_q.size(), 0);
        send_frame(1, 1'b0);
        check_step("post_rst_step", v400);

        idle(2);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Streaming 3x3 Sobel edge-magnitude stage sitting directly downstream of the greyscale converter. Consumes the 12-bit greyscale pixel stream in raster order, holds two full lines in internal line buffers to form a sliding 3x3 window, and emits one saturated gradient magnitude per interior pixel. Output feeds the display/capture path in place of the raw greyscale stream.

## Interface
- IMG_WIDTH, 640, pixels per line; window, line buffers and column counter sized from it; minimum 3
- THRESH, 12'd256, edge threshold used only when SOBEL_THRESH_EN is defined
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- frame_start  input  1  marks the pixel presented this cycle as row 0, col 0; only meaningful when pix_valid=1
- pix_valid  input  1  pix_in valid this cycle; may drop for any number of cycles (gaps)
- pix_in  input  12  greyscale pixel
- edge_valid  output  1  edge_out valid this cycle; single-cycle pulse per result
- edge_out  output  12  edge magnitude (or binarized edge) for the window centre

## Operation
- Pixel accepted only on cycles with pix_valid=1; nothing advances on gap cycles.
- After reset the block is unarmed: accepted pixels are discarded until an accepted pixel with frame_start=1 arms it.
- Counters: col (0..IMG_WIDTH-1), row (saturating). Pixel with frame_start is (0,0). col wraps to 0 after IMG_WIDTH-1, row increments on wrap.
- frame_start mid-frame: counters restart at (0,0) for that pixel; no output generated for the new frame until its row 2, col 2. Line-buffer contents need not be cleared.
- Line buffers: two IMG_WIDTH x 12 stores (rows r-1, r-2), written at the col index on each accepted pixel; read and write of the same index in the same cycle returns the old data.
- Window: 3x3 register array shifted one column left per accepted pixel; new right column = {line r-2[col], line r-1[col], pix_in}.
- Result generated when the accepted pixel is at row>=2 and col>=2; window centre is pixel (row-1, col-1). Border pixels (row 0, last row, col 0, last col) produce no output; output count per frame = (H-2)*(IMG_WIDTH-2).
- Arithmetic: Gx = (p02+2p12+p22) - (p00+2p10+p20); Gy = (p20+2p21+p22) - (p00+2p01+p02); 16-bit signed, no overflow (|G| <= 16380). mag = |Gx|+|Gy| in 16 bits unsigned, saturated to 4095.

## Timing
- Reset values: edge_valid=0, edge_out=0, col=0, row=0, unarmed, window=0. Line buffers not reset.
- rst asserted mid-frame: edge_valid=0 from the cycle after the reset edge; any in-flight result is dropped.
- Latency: 2 clocks. Accepted pixel sampled at edge E0 updates the window; result registered at E1; edge_valid=1 during the cycle following E1.
- Throughput: one result per accepted pixel at full rate (pix_valid=1 every cycle).
- Pipeline advances every clock regardless of pix_valid; gaps do not stall an in-flight result.
- No backpressure; downstream must accept every edge_valid pulse.

## Configuration
- SOBEL_THRESH_EN defined: edge_out = 12'hFFF when mag >= THRESH, else 0.
- SOBEL_THRESH_EN undefined: edge_out = saturated mag; THRESH unused.
- Latency and edge_valid behaviour identical in both builds.

## Test plan
- IMG_WIDTH=8, 4 lines constant 12'd700 -> exactly 12 edge_valid pulses, all edge_out=0.
- IMG_WIDTH=8, cols 0..3 = 0, cols 4..7 = 100, 4 lines -> per row of results edge_out = 0,0,400,400,0,0 (centres col 1..6).
- Same step with 0 vs 4095 -> edge_out=4095 at the two step centres (16380 saturated).
- Full-rate stream vs. random pix_valid gaps (1-5 cycles) on same image -> identical edge_out sequence; each edge_valid exactly 2 edges after the completing pixel's acceptance.
- Pixels before first frame_start and rst pulsed mid-frame -> no edge_valid until row 2 col 2 of the next frame_start frame; edge_valid=0 the cycle after reset.
- SOBEL_THRESH_EN, THRESH=400, step 0/100 image -> 12'hFFF at step centres, 0 elsewhere; THRESH=401 -> all 0.
